// File: rtl/pri_enc_pkg.sv
// Shared constants, FSM state type and the rotate helper for the queued priority encoder.
// Optional one-hot output is enabled by PRI_ENC_QUEUED_ONEHOT_EN (see pri_enc_queued).
package pri_enc_pkg;

  localparam int PRI_FIXED = 0;
  localparam int PRI_RR    = 1;
  localparam int MAX_N     = 64;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Rotate the low n bits of v left by sh (sh <= n); bits above n are returned as 0.
  function automatic logic [MAX_N-1:0] rot_left(input logic [MAX_N-1:0] v,
                                                input int unsigned sh,
                                                input int unsigned n);
    logic [MAX_N-1:0] mask;
    logic [MAX_N-1:0] vm;
    mask = (MAX_N'(1) << n) - MAX_N'(1);
    vm   = v & mask;
    return ((vm << sh) | (vm >> (n - sh))) & mask;
  endfunction

endpackage

// File: rtl/pri_enc_queued_if.sv
// Output handshake of pri_enc_queued: valid/ready plus granted index.
// out_oh exists only when PRI_ENC_QUEUED_ONEHOT_EN is defined.
interface pri_enc_queued_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
  logic [N-1:0] out_oh;
`endif

  modport master (
    output out_valid,
    output out_idx,
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
    output out_oh,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
    input  out_oh,
`endif
    output out_ready
  );

endinterface

// File: rtl/pri_enc_queued_sel.sv
// Combinational selector: highest pending index (fixed) or first pending index
// searching downward from ptr with wrap (round-robin). No macro dependencies.
module pri_enc_sel
  import pri_enc_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int RR = PRI_FIXED,
  localparam int W  = $clog2(N)
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  assign any = |pend;

  generate
    if (RR == PRI_RR) begin : g_rr
      logic [N-1:0] rot;
      int unsigned  hi;
      int unsigned  j;

      // Rotation puts pend[ptr] at the MSB, so a plain highest-bit search walks ptr, ptr-1, ... with wrap.
      always_comb begin
        rot = N'(rot_left(MAX_N'(pend), (N - 1) - 32'(ptr), N));
        hi  = 0;
        for (int i = 0; i < N; i++) begin
          if (rot[i]) hi = i;
        end
        j = hi + 32'(ptr) + 1;
        if (j >= N) j = j - N;
        sel = W'(j);
      end
    end else begin : g_fix
      logic unused_ptr;
      assign unused_ptr = ^ptr;

      always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
          if (pend[i]) sel = W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/pri_enc_queued.sv
// Sticky request capture with fixed/round-robin selection onto a registered valid/ready port.
// Define PRI_ENC_QUEUED_ONEHOT_EN to add the registered one-hot output out_oh.
module pri_enc_queued
  import pri_enc_pkg::*;
#(
  parameter int N  = 8,
  parameter int RR = PRI_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  pri_enc_queued_if.master         out_if,
  output logic [N-1:0]             pend,
  output logic                     none
);

  localparam int W = $clog2(N);

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] load_mask;
  logic [W-1:0] sel;
  logic         any;
  logic         load;
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
  logic [N-1:0] oh_q, oh_d;
`endif

  pri_enc_sel #(.N(N), .RR(RR)) u_sel (
    .pend (pend_q),
    .ptr  (ptr_q),
    .sel  (sel),
    .any  (any)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    load      = any && ((state_q == ST_EMPTY) || out_if.out_ready);
    load_mask = load ? (N'(1) << sel) : '0;
    // A same-cycle re-request of the loaded bit keeps it pending as a fresh event.
    pend_d    = (pend_q & ~load_mask) | req;
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
    oh_d      = oh_q;
`endif

    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (out_if.out_ready && !any) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase

    if (load) begin
      idx_d = sel;
      if (RR == PRI_RR) ptr_d = (sel == '0) ? W'(N - 1) : sel - W'(1);
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
      oh_d  = load_mask;
`endif
    end
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
    else if (state_d == ST_EMPTY) begin
      oh_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pend_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= W'(N - 1);
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
      oh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
      oh_q    <= oh_d;
`endif
    end
  end

  assign out_if.out_valid = (state_q == ST_FULL);
  assign out_if.out_idx   = idx_q;
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
  assign out_if.out_oh    = oh_q;
`endif
  assign pend = pend_q;
  assign none = (pend_q == '0) && (state_q == ST_EMPTY);

endmodule

// File: tb/tb_pri_enc_queued.sv
// Self-checking bench: fixed N=8, round-robin N=8 and round-robin N=5 instances
// against vector tables, directed sequences and a queue-free behavioural model.
module tb_pri_enc_queued;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] req_fix, req_rr, pend_fix, pend_rr;
  logic [4:0] req_n5, pend_n5;
  logic       none_fix, none_rr, none_n5;

  int n_checks = 0;
  int n_fail   = 0;

  pri_enc_queued_if #(.N(8)) if_fix ();
  pri_enc_queued_if #(.N(8)) if_rr ();
  pri_enc_queued_if #(.N(5)) if_n5 ();

  pri_enc_queued #(.N(8), .RR(0)) u_fix (.clk(clk), .rst(rst), .req(req_fix), .out_if(if_fix), .pend(pend_fix), .none(none_fix));
  pri_enc_queued #(.N(8), .RR(1)) u_rr  (.clk(clk), .rst(rst), .req(req_rr),  .out_if(if_rr),  .pend(pend_rr),  .none(none_rr));
  pri_enc_queued #(.N(5), .RR(1)) u_n5  (.clk(clk), .rst(rst), .req(req_n5),  .out_if(if_n5),  .pend(pend_n5),  .none(none_n5));

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       exp_valid;
    int         exp_idx;
    logic [7:0] exp_pend;
    logic       exp_none;
  } vec_t;

  typedef struct {
    bit [7:0] pend;
    bit       valid;
    int       idx;
    int       ptr;
  } mstate_t;

  vec_t    vecs[19];
  mstate_t m_fix, m_rr, m_n5;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_fix = '0; req_rr = '0; req_n5 = '0;
    if_fix.out_ready = 1'b1; if_rr.out_ready = 1'b1; if_n5.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Next state from the rules: pick by priority order, load if the output slot is free or draining.
  function automatic mstate_t mstep(input mstate_t m, input int n, input bit rr,
                                    input bit [7:0] req, input bit ready);
    mstate_t r;
    int      sel;
    bit [7:0] one;
    r   = m;
    sel = -1;
    if (rr) begin
      for (int k = 0; k < n; k++) begin
        int c;
        c = (m.ptr - k + n) % n;
        if (sel < 0 && m.pend[c]) sel = c;
      end
    end else begin
      for (int c = n - 1; c >= 0; c--) if (sel < 0 && m.pend[c]) sel = c;
    end
    r.pend = m.pend | req;
    if (sel >= 0 && (!m.valid || ready)) begin
      one     = 8'd1 << sel;
      r.valid = 1'b1;
      r.idx   = sel;
      r.pend  = (m.pend & ~one) | req;
      if (rr) r.ptr = (sel == 0) ? n - 1 : sel - 1;
    end else if (m.valid && ready) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

  function automatic mstate_t mreset(input int n);
    mstate_t r;
    r.pend = '0; r.valid = 1'b0; r.idx = 0; r.ptr = n - 1;
    return r;
  endfunction

  task automatic cmp(input string tag, input mstate_t m, input logic v, input int idx,
                     input int pend, input logic none);
    check({tag, "_valid"}, int'(v), int'(m.valid));
    check({tag, "_idx"}, idx, m.idx);
    check({tag, "_pend"}, pend, int'(m.pend));
    check({tag, "_none"}, int'(none), int'(m.pend == 0 && !m.valid));
  endtask

  initial begin
    int rr_exp[10];
    rr_exp = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};

    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 0, 8'hA5, 1'b0};
    vecs[1]  = '{8'h00, 1'b1, 1'b1, 7, 8'h25, 1'b0};
    vecs[2]  = '{8'h00, 1'b1, 1'b1, 5, 8'h05, 1'b0};
    vecs[3]  = '{8'h00, 1'b1, 1'b1, 2, 8'h01, 1'b0};
    vecs[4]  = '{8'h00, 1'b1, 1'b1, 0, 8'h00, 1'b0};
    vecs[5]  = '{8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1};
    vecs[6]  = '{8'h48, 1'b0, 1'b0, 0, 8'h48, 1'b0};
    vecs[7]  = '{8'h00, 1'b0, 1'b1, 6, 8'h08, 1'b0};
    vecs[8]  = '{8'h00, 1'b0, 1'b1, 6, 8'h08, 1'b0};
    vecs[9]  = '{8'h00, 1'b0, 1'b1, 6, 8'h08, 1'b0};
    vecs[10] = '{8'h00, 1'b0, 1'b1, 6, 8'h08, 1'b0};
    vecs[11] = '{8'h00, 1'b0, 1'b1, 6, 8'h08, 1'b0};
    vecs[12] = '{8'h00, 1'b1, 1'b1, 3, 8'h00, 1'b0};
    vecs[13] = '{8'h00, 1'b1, 1'b0, 3, 8'h00, 1'b1};
    vecs[14] = '{8'h10, 1'b1, 1'b0, 3, 8'h10, 1'b0};
    vecs[15] = '{8'h10, 1'b1, 1'b1, 4, 8'h10, 1'b0};
    vecs[16] = '{8'h00, 1'b0, 1'b1, 4, 8'h10, 1'b0};
    vecs[17] = '{8'h00, 1'b1, 1'b1, 4, 8'h00, 1'b0};
    vecs[18] = '{8'h00, 1'b1, 1'b0, 4, 8'h00, 1'b1};

    do_reset();
    check("rst_fix_valid", int'(if_fix.out_valid), 0);
    check("rst_fix_idx", int'(if_fix.out_idx), 0);
    check("rst_fix_pend", int'(pend_fix), 0);
    check("rst_fix_none", int'(none_fix), 1);
    check("rst_rr_none", int'(none_rr), 1);
    check("rst_n5_none", int'(none_n5), 1);

    // Fixed priority: burst drain, stall, same-cycle re-request
    for (int i = 0; i < 19; i++) begin
      req_fix = vecs[i].req;
      if_fix.out_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d_valid", i), int'(if_fix.out_valid), int'(vecs[i].exp_valid));
      check($sformatf("vec%0d_idx", i), int'(if_fix.out_idx), vecs[i].exp_idx);
      check($sformatf("vec%0d_pend", i), int'(pend_fix), int'(vecs[i].exp_pend));
      check($sformatf("vec%0d_none", i), int'(none_fix), int'(vecs[i].exp_none));
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
      check($sformatf("vec%0d_oh", i), int'(if_fix.out_oh),
            vecs[i].exp_valid ? (1 << vecs[i].exp_idx) : 0);
`endif
    end

    // Async reset while holding a grant with pend=3C
    req_fix = 8'hBC; if_fix.out_ready = 1'b0;
    tick();
    req_fix = 8'h00;
    tick();
    check("arst_pre_valid", int'(if_fix.out_valid), 1);
    check("arst_pre_idx", int'(if_fix.out_idx), 7);
    check("arst_pre_pend", int'(pend_fix), 8'h3C);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(if_fix.out_valid), 0);
    check("arst_idx", int'(if_fix.out_idx), 0);
    check("arst_pend", int'(pend_fix), 0);
    check("arst_none", int'(none_fix), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    req_fix = 8'h24; if_fix.out_ready = 1'b1;
    tick();
    req_fix = 8'h00;
    tick();
    check("arst_post_idx0", int'(if_fix.out_idx), 5);
    tick();
    check("arst_post_idx1", int'(if_fix.out_idx), 2);

    // Round-robin fairness under continuous requests
    do_reset();
    req_rr = 8'hFF;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e >= 2) begin
        check($sformatf("rr_all_valid%0d", e), int'(if_rr.out_valid), 1);
        check($sformatf("rr_all_idx%0d", e), int'(if_rr.out_idx), rr_exp[e-2]);
      end
    end

    // Round-robin: 0 wins over 7 right after 7 was granted
    do_reset();
    req_rr = 8'h80;
    tick();
    req_rr = 8'h81;
    tick();
    check("rr_wrap_idx7", int'(if_rr.out_idx), 7);
    req_rr = 8'h00;
    tick();
    check("rr_wrap_idx0", int'(if_rr.out_idx), 0);
    tick();
    check("rr_wrap_idx7b", int'(if_rr.out_idx), 7);
    tick();
    check("rr_wrap_valid", int'(if_rr.out_valid), 0);
    check("rr_wrap_none", int'(none_rr), 1);

    // Non-power-of-two round-robin
    do_reset();
    req_n5 = 5'b10011;
    tick();
    req_n5 = '0;
    tick();
    check("n5_idx4", int'(if_n5.out_idx), 4);
    tick();
    check("n5_idx1", int'(if_n5.out_idx), 1);
    tick();
    check("n5_idx0", int'(if_n5.out_idx), 0);
    tick();
    check("n5_done", int'(if_n5.out_valid), 0);

    // Randomised run against the behavioural model
    do_reset();
    m_fix = mreset(8); m_rr = mreset(8); m_n5 = mreset(5);
    for (int c = 0; c < 600; c++) begin
      bit [7:0] rf, rr;
      bit [4:0] r5;
      bit       kf, kr, k5;
      rf = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      r5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h00;
      kf = ($urandom_range(0, 9) < 7);
      kr = ($urandom_range(0, 9) < 7);
      k5 = ($urandom_range(0, 9) < 7);
      req_fix = rf; req_rr = rr; req_n5 = r5;
      if_fix.out_ready = kf; if_rr.out_ready = kr; if_n5.out_ready = k5;
      m_fix = mstep(m_fix, 8, 1'b0, rf, kf);
      m_rr  = mstep(m_rr, 8, 1'b1, rr, kr);
      m_n5  = mstep(m_n5, 5, 1'b1, {3'b000, r5}, k5);
      tick();
      cmp($sformatf("rnd%0d_fix", c), m_fix, if_fix.out_valid, int'(if_fix.out_idx), int'(pend_fix), none_fix);
      cmp($sformatf("rnd%0d_rr", c), m_rr, if_rr.out_valid, int'(if_rr.out_idx), int'(pend_rr), none_rr);
      cmp($sformatf("rnd%0d_n5", c), m_n5, if_n5.out_valid, int'(if_n5.out_idx), int'(pend_n5), none_n5);
      check($sformatf("rnd%0d_n5_range", c), int'(if_n5.out_idx <= 3'd4), 1);
`ifdef PRI_ENC_QUEUED_ONEHOT_EN
      check($sformatf("rnd%0d_rr_oh", c), int'(if_rr.out_oh), m_rr.valid ? (1 << m_rr.idx) : 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
